// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings and arbiter state type.
// Commands are {CS_n, RAS_n, CAS_n, WE_n}.
package sdram_pkg;

   localparam logic [3:0] CMD_NOP                = 4'b0111;
   localparam logic [3:0] CMD_ACTIVE             = 4'b0011;
   localparam logic [3:0] CMD_READ               = 4'b0101;
   localparam logic [3:0] CMD_WRITE              = 4'b0100;
   localparam logic [3:0] CMD_BURST_TERM         = 4'b0110;
   localparam logic [3:0] CMD_PRECHARGE          = 4'b0010;
   localparam logic [3:0] CMD_AUTO_REFRESH       = 4'b0001;
   localparam logic [3:0] CMD_LOAD_MODE_REGISTER = 4'b0000;

   localparam logic [10:0] ADDR_IDLE = 11'h7FF;

   typedef enum logic [2:0] {
      ST_INIT    = 3'd0,
      ST_ARB     = 3'd1,
      ST_REFRESH = 3'd2,
      ST_WRITE   = 3'd3,
      ST_READ    = 3'd4
   } arb_state_t;

   typedef enum logic {
      GRANT_WRITE = 1'b0,
      GRANT_READ  = 1'b1
   } grant_t;

endpackage

// File: rtl/sdram_ref_timer.sv
// Refresh period counter; raises ref_req every REF_PERIOD_CYC enabled cycles
// and flags ref_overrun when a new period expires with a refresh still unserviced.
module sdram_ref_timer #(
   parameter int unsigned REF_PERIOD_CYC = 750
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic clear,
   output logic ref_req,
   output logic ref_overrun
);

   localparam int unsigned CW = (REF_PERIOD_CYC > 1) ? $clog2(REF_PERIOD_CYC) : 1;

   logic [CW-1:0] count;
   logic          terminal;

   assign terminal = enable && (count == CW'(REF_PERIOD_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (enable) begin
         if (terminal) count <= '0;
         else          count <= count + 1'b1;
      end
   end

   // A fresh period expiring wins over a same-cycle service clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         ref_req     <= 1'b0;
         ref_overrun <= 1'b0;
      end else if (terminal) begin
         ref_req <= 1'b1;
         if (ref_req && !clear) ref_overrun <= 1'b1;
      end else if (clear) begin
         ref_req <= 1'b0;
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Post-init SDRAM command scheduler: init pass-through, periodic refresh,
// and round-robin bus grant between the write and read burst engines.
module sdram_arbiter
   import sdram_pkg::*;
#(
   parameter int unsigned REF_PERIOD_CYC = 750,
   parameter int unsigned tRP            = 3,
   parameter int unsigned tRFC           = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        init_done,
   input  logic [3:0]  init_cmd,
   input  logic [10:0] init_addr,
   input  logic [1:0]  init_ba,
   input  logic        wr_req,
   output logic        wr_ack,
   input  logic        wr_end,
   input  logic [3:0]  wr_cmd,
   input  logic [10:0] wr_addr,
   input  logic [1:0]  wr_ba,
   input  logic        rd_req,
   output logic        rd_ack,
   input  logic        rd_end,
   input  logic [3:0]  rd_cmd,
   input  logic [10:0] rd_addr,
   input  logic [1:0]  rd_ba,
   output logic        ref_req,
   output logic        ref_overrun,
   output logic [3:0]  sdr_cmd,
   output logic [10:0] sdr_addr,
   output logic [1:0]  sdr_ba,
   output logic [2:0]  arb_state
);

   localparam int unsigned STEP_LAST = tRP + 2 * tRFC - 1;
   localparam int unsigned SW        = $clog2(STEP_LAST + 1);

   arb_state_t    state;
   grant_t        last_grant;
   logic [SW-1:0] step;
   logic          wr_ok, rd_ok, grant_wr, grant_rd;
   logic          ref_clear;

   assign arb_state = state;

   // An engine whose end pulse is present this cycle is not eligible for a grant.
   always_comb begin
      wr_ok    = wr_req && !wr_end;
      rd_ok    = rd_req && !rd_end;
      grant_wr = wr_ok && (!rd_ok || (last_grant == GRANT_READ));
      grant_rd = rd_ok && !grant_wr;
   end

   assign ref_clear = (state == ST_ARB) && ref_req;

   sdram_ref_timer #(
      .REF_PERIOD_CYC (REF_PERIOD_CYC)
   ) u_ref_timer (
      .clk         (clk),
      .rst         (rst),
      .enable      (state != ST_INIT),
      .clear       (ref_clear),
      .ref_req     (ref_req),
      .ref_overrun (ref_overrun)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_INIT;
         last_grant <= GRANT_READ;
         step       <= '0;
         wr_ack     <= 1'b0;
         rd_ack     <= 1'b0;
         sdr_cmd    <= CMD_NOP;
         sdr_addr   <= ADDR_IDLE;
         sdr_ba     <= '0;
      end else begin
         wr_ack <= 1'b0;
         rd_ack <= 1'b0;
         case (state)
            ST_INIT: begin
               sdr_cmd  <= init_cmd;
               sdr_addr <= init_addr;
               sdr_ba   <= init_ba;
               if (init_done) state <= ST_ARB;
            end
            ST_ARB: begin
               sdr_cmd  <= CMD_NOP;
               sdr_addr <= ADDR_IDLE;
               sdr_ba   <= '0;
               if (ref_req) begin
                  state <= ST_REFRESH;
                  step  <= '0;
               end else if (grant_wr) begin
                  state      <= ST_WRITE;
                  wr_ack     <= 1'b1;
                  last_grant <= GRANT_WRITE;
               end else if (grant_rd) begin
                  state      <= ST_READ;
                  rd_ack     <= 1'b1;
                  last_grant <= GRANT_READ;
               end
            end
            ST_REFRESH: begin
               sdr_addr <= ADDR_IDLE;
               sdr_ba   <= '0;
               if (step == '0)
                  sdr_cmd <= CMD_PRECHARGE;
               else if ((step == SW'(tRP)) || (step == SW'(tRP + tRFC)))
                  sdr_cmd <= CMD_AUTO_REFRESH;
               else
                  sdr_cmd <= CMD_NOP;
               step <= step + 1'b1;
               if (step == SW'(STEP_LAST)) state <= ST_ARB;
            end
            ST_WRITE: begin
               sdr_cmd  <= wr_cmd;
               sdr_addr <= wr_addr;
               sdr_ba   <= wr_ba;
               if (wr_end) state <= ST_ARB;
            end
            ST_READ: begin
               sdr_cmd  <= rd_cmd;
               sdr_addr <= rd_addr;
               sdr_ba   <= rd_ba;
               if (rd_end) state <= ST_ARB;
            end
            default: state <= ST_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scenario bench for sdram_arbiter with a shortened refresh period.
module tb_sdram_arbiter;

   localparam logic [3:0] C_NOP = 4'b0111;
   localparam logic [3:0] C_PRE = 4'b0010;
   localparam logic [3:0] C_AR  = 4'b0001;
   localparam logic [2:0] S_INIT = 3'd0, S_ARB = 3'd1, S_REF = 3'd2, S_WR = 3'd3, S_RD = 3'd4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        init_done = 1'b0;
   logic [3:0]  init_cmd = 4'b0111;
   logic [10:0] init_addr = '0;
   logic [1:0]  init_ba = '0;
   logic        wr_req = 1'b0, wr_end = 1'b0, rd_req = 1'b0, rd_end = 1'b0;
   logic [3:0]  wr_cmd = 4'b0111, rd_cmd = 4'b0111;
   logic [10:0] wr_addr = '0, rd_addr = '0;
   logic [1:0]  wr_ba = '0, rd_ba = '0;
   logic        wr_ack, rd_ack, ref_req, ref_overrun;
   logic [3:0]  sdr_cmd;
   logic [10:0] sdr_addr;
   logic [1:0]  sdr_ba;
   logic [2:0]  arb_state;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [16:0] exp_q[$];

   sdram_arbiter #(
      .REF_PERIOD_CYC (100),
      .tRP            (3),
      .tRFC           (7)
   ) dut (
      .clk (clk), .rst (rst), .init_done (init_done),
      .init_cmd (init_cmd), .init_addr (init_addr), .init_ba (init_ba),
      .wr_req (wr_req), .wr_ack (wr_ack), .wr_end (wr_end),
      .wr_cmd (wr_cmd), .wr_addr (wr_addr), .wr_ba (wr_ba),
      .rd_req (rd_req), .rd_ack (rd_ack), .rd_end (rd_end),
      .rd_cmd (rd_cmd), .rd_addr (rd_addr), .rd_ba (rd_ba),
      .ref_req (ref_req), .ref_overrun (ref_overrun),
      .sdr_cmd (sdr_cmd), .sdr_addr (sdr_addr), .sdr_ba (sdr_ba),
      .arb_state (arb_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; init_done = 1'b0; init_cmd = C_NOP;
      wr_req = 1'b0; wr_end = 1'b0; rd_req = 1'b0; rd_end = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   function automatic logic [3:0] ref_cmd_at(int i);
      if (i == 102) return C_PRE;
      if (i == 105 || i == 112) return C_AR;
      return C_NOP;
   endfunction

   task automatic test_reset();
      logic [16:0] e, got;
      rst = 1'b1; init_cmd = 4'b0000; init_addr = 11'h155; init_ba = 2'd3;
      tick(); tick();
      n_checks++;
      if ({sdr_cmd, sdr_addr, sdr_ba, arb_state, wr_ack, rd_ack, ref_req, ref_overrun} !==
          {C_NOP, 11'h7FF, 2'b00, S_INIT, 4'b0000}) begin
         n_fail++;
         $display("FAIL reset_state: cmd=%b addr=%h ba=%0d st=%0d acks=%b%b ref=%b ovr=%b, required 0111/7ff/0/0/00/0/0",
                  sdr_cmd, sdr_addr, sdr_ba, arb_state, wr_ack, rd_ack, ref_req, ref_overrun);
      end
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         init_cmd  = 4'(k * 3 + 1);
         init_addr = 11'(k * 37 + 5);
         init_ba   = 2'(k);
         exp_q.push_back({init_cmd, init_addr, init_ba});
         tick();
         e = exp_q.pop_front();
         got = {sdr_cmd, sdr_addr, sdr_ba};
         n_checks++;
         if (got !== e || arb_state !== S_INIT) begin
            n_fail++;
            $display("FAIL init_passthru[%0d]: got %h st=%0d, required %h st=0", k, got, arb_state, e);
         end
      end
   endtask

   task automatic test_refresh_timing();
      logic [16:0] e, got;
      do_reset();
      init_done = 1'b1;
      tick();
      for (int i = 1; i <= 119; i++) begin
         if (i >= 101) exp_q.push_back({ref_cmd_at(i), 11'h7FF, 2'b00});
         tick();
         if (i == 99) begin
            n_checks++;
            if (ref_req !== 1'b0) begin n_fail++; $display("FAIL ref_req_early: got %b required 0", ref_req); end
         end
         if (i == 100) begin
            n_checks++;
            if (ref_req !== 1'b1) begin n_fail++; $display("FAIL ref_req_rise: got %b required 1", ref_req); end
         end
         if (i == 101) begin
            n_checks++;
            if (ref_req !== 1'b0 || arb_state !== S_REF) begin
               n_fail++; $display("FAIL ref_enter: ref_req=%b st=%0d required 0/2", ref_req, arb_state);
            end
         end
         if (i >= 101) begin
            e = exp_q.pop_front();
            got = {sdr_cmd, sdr_addr, sdr_ba};
            n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL ref_seq[T+%0d]: got %h required %h", i, got, e); end
         end
         if (i == 117 || i == 118) begin
            n_checks++;
            if (arb_state !== ((i == 117) ? S_REF : S_ARB)) begin
               n_fail++; $display("FAIL ref_exit[T+%0d]: st=%0d required %0d", i, arb_state, (i == 117) ? S_REF : S_ARB);
            end
         end
      end
      init_done = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [16:0] e, got;
      do_reset();
      init_done = 1'b1;
      tick(); tick(); tick();
      wr_req = 1'b1; rd_req = 1'b1;
      tick();
      n_checks++;
      if ({wr_ack, rd_ack, arb_state} !== {2'b10, S_WR}) begin
         n_fail++; $display("FAIL rr_first: wr_ack=%b rd_ack=%b st=%0d required 1/0/3", wr_ack, rd_ack, arb_state);
      end
      wr_req = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         wr_cmd = 4'(k); wr_addr = 11'(k * 91); wr_ba = 2'(k + 1);
         exp_q.push_back({wr_cmd, wr_addr, wr_ba});
         if (k == 10) wr_end = 1'b1;
         tick();
         e = exp_q.pop_front();
         got = {sdr_cmd, sdr_addr, sdr_ba};
         n_checks++;
         if (got !== e) begin n_fail++; $display("FAIL wr_passthru[%0d]: got %h required %h", k, got, e); end
      end
      wr_end = 1'b0;
      n_checks++;
      if ({arb_state, rd_ack} !== {S_ARB, 1'b0}) begin
         n_fail++; $display("FAIL wr_release: st=%0d rd_ack=%b required 1/0", arb_state, rd_ack);
      end
      tick();
      n_checks++;
      if ({rd_ack, arb_state, sdr_cmd} !== {1'b1, S_RD, C_NOP}) begin
         n_fail++; $display("FAIL rd_after_wr: rd_ack=%b st=%0d cmd=%b required 1/4/0111", rd_ack, arb_state, sdr_cmd);
      end
      rd_req = 1'b0; rd_end = 1'b1; tick(); rd_end = 1'b0;
      wr_req = 1'b1; wr_end = 1'b1;
      tick();
      n_checks++;
      if ({wr_ack, arb_state} !== {1'b0, S_ARB}) begin
         n_fail++; $display("FAIL end_blocks_grant: wr_ack=%b st=%0d required 0/1", wr_ack, arb_state);
      end
      wr_end = 1'b0;
      tick();
      wr_req = 1'b0;
      n_checks++;
      if ({wr_ack, arb_state} !== {1'b1, S_WR}) begin
         n_fail++; $display("FAIL wr_single: wr_ack=%b st=%0d required 1/3", wr_ack, arb_state);
      end
      wr_end = 1'b1; tick(); wr_end = 1'b0;
      wr_req = 1'b1; rd_req = 1'b1;
      tick();
      n_checks++;
      if ({wr_ack, rd_ack, arb_state} !== {2'b01, S_RD}) begin
         n_fail++; $display("FAIL rr_after_write: wr_ack=%b rd_ack=%b st=%0d required 0/1/4", wr_ack, rd_ack, arb_state);
      end
      wr_req = 1'b0; rd_req = 1'b0;
      rd_end = 1'b1; tick(); rd_end = 1'b0;
      init_done = 1'b0;
   endtask

   task automatic test_refresh_during_write();
      logic early_rd;
      early_rd = 1'b0;
      do_reset();
      init_done = 1'b1;
      tick();
      wr_req = 1'b1;
      tick();
      wr_req = 1'b0; rd_req = 1'b1;
      for (int i = 2; i <= 139; i++) begin
         if (i == 120) wr_end = 1'b1;
         tick();
         wr_end = 1'b0;
         if (i < 139 && rd_ack) early_rd = 1'b1;
         if (i == 110) begin
            n_checks++;
            if ({arb_state, ref_req} !== {S_WR, 1'b1}) begin
               n_fail++; $display("FAIL wr_holds: st=%0d ref_req=%b required 3/1", arb_state, ref_req);
            end
         end
         if (i == 121) begin
            n_checks++;
            if (arb_state !== S_REF) begin n_fail++; $display("FAIL ref_before_rd: st=%0d required 2", arb_state); end
         end
      end
      n_checks++;
      if (early_rd) begin n_fail++; $display("FAIL rd_ack_early: got 1 before T+139 required 0"); end
      n_checks++;
      if ({rd_ack, arb_state} !== {1'b1, S_RD}) begin
         n_fail++; $display("FAIL rd_after_ref: rd_ack=%b st=%0d required 1/4", rd_ack, arb_state);
      end
      rd_req = 1'b0;
      init_done = 1'b0;
   endtask

   task automatic test_overrun();
      do_reset();
      init_done = 1'b1;
      tick();
      wr_req = 1'b1;
      tick();
      wr_req = 1'b0;
      for (int i = 2; i <= 270; i++) begin
         if (i == 250) wr_end = 1'b1;
         tick();
         wr_end = 1'b0;
         if (i == 199) begin
            n_checks++;
            if ({ref_req, ref_overrun} !== 2'b10) begin
               n_fail++; $display("FAIL ovr_early: ref_req=%b ovr=%b required 1/0", ref_req, ref_overrun);
            end
         end
         if (i == 200) begin
            n_checks++;
            if (ref_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b required 1", ref_overrun); end
         end
      end
      n_checks++;
      if ({arb_state, ref_req, ref_overrun} !== {S_ARB, 2'b01}) begin
         n_fail++; $display("FAIL ovr_sticky: st=%0d ref_req=%b ovr=%b required 1/0/1", arb_state, ref_req, ref_overrun);
      end
      init_done = 1'b0;
   endtask

   task automatic test_reset_mid_refresh();
      logic saw_ar;
      saw_ar = 1'b0;
      do_reset();
      init_done = 1'b1;
      tick();
      for (int i = 1; i <= 105; i++) tick();
      rst = 1'b1; init_done = 1'b0; init_cmd = C_NOP;
      tick();
      n_checks++;
      if ({sdr_cmd, arb_state, ref_req, ref_overrun} !== {C_NOP, S_INIT, 2'b00}) begin
         n_fail++; $display("FAIL rst_mid_ref: cmd=%b st=%0d ref=%b ovr=%b required 0111/0/0/0",
                            sdr_cmd, arb_state, ref_req, ref_overrun);
      end
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (sdr_cmd === C_AR || arb_state !== S_INIT) saw_ar = 1'b1;
      end
      n_checks++;
      if (saw_ar) begin n_fail++; $display("FAIL rst_no_autoref: refresh activity after reset, required none"); end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_refresh_timing();
      test_back_to_back();
      test_refresh_during_write();
      test_overrun();
      test_reset_mid_refresh();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
